// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: owns the oversample edge counter and the bit counter,
// drives the sampler/deserializer/checker enables and decides frame acceptance.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic                   PAR_EN,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  input  logic                   sampled_bit,
  input  logic                   strt_glitch,
  input  logic                   par_err,
  input  logic                   stp_err,
  output logic [PRESC_WIDTH-1:0] edge_cnt,
  output logic [3:0]             bit_cnt,
  output logic                   dat_samp_en,
  output logic                   deser_en,
  output logic                   strt_chk_en,
  output logic                   par_check_en,
  output logic                   stp_chk_en,
  output logic                   data_valid,
  output logic                   frame_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [PRESC_WIDTH-1:0] edge_q, edge_d;
  logic [3:0]             bit_q, bit_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic                   par_en_q, par_en_d;
  logic                   err_q, err_d;
  logic                   dv_q, dv_d;
  logic                   fe_q, fe_d;

  logic [PRESC_WIDTH-1:0] last_edge;
  logic [PRESC_WIDTH-1:0] mid_edge;
  logic                   bit_end;
  logic                   in_window;

  // The sampled bit feeds the deserializer directly; sequencing never needs it.
  logic unused_sampled_bit;
  assign unused_sampled_bit = sampled_bit;

  function automatic logic [PRESC_WIDTH-1:0] legal_presc(input logic [PRESC_WIDTH-1:0] p);
    if (p == PRESC_WIDTH'(16) || p == PRESC_WIDTH'(32)) begin
      return p;
    end
    return PRESC_WIDTH'(8);
  endfunction

  assign last_edge = presc_q - PRESC_WIDTH'(1);
  assign mid_edge  = (presc_q >> 1) + PRESC_WIDTH'(1);
  assign bit_end   = (edge_q == last_edge);
  assign in_window = (edge_q >= mid_edge);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      edge_q   <= '0;
      bit_q    <= '0;
      presc_q  <= PRESC_WIDTH'(8);
      par_en_q <= 1'b0;
      err_q    <= 1'b0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      presc_q  <= presc_d;
      par_en_q <= par_en_d;
      err_q    <= err_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    bit_d    = bit_q;
    presc_d  = presc_q;
    par_en_d = par_en_q;
    err_d    = err_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;

    if (state_q != IDLE) begin
      if (bit_end) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + PRESC_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!RX_IN) begin
          state_d  = START;
          presc_d  = legal_presc(Prescale);
          par_en_d = PAR_EN;
        end
      end
      START: begin
        if (bit_end) begin
          if (strt_glitch) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end && bit_q == 4'(DATA_WIDTH)) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          err_d   = par_err;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          fe_d  = stp_err | err_q;
          dv_d  = ~(stp_err | err_q);
          err_d = 1'b0;
          bit_d = '0;
          // A low line at the stop bit end is already the next start bit.
          if (!RX_IN) begin
            state_d  = START;
            presc_d  = legal_presc(Prescale);
            par_en_d = PAR_EN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
    dat_samp_en  = (state_q != IDLE);
    deser_en     = (state_q == DATA)   && bit_end;
    strt_chk_en  = (state_q == START)  && in_window;
    par_check_en = (state_q == PARITY) && in_window;
    stp_chk_en   = (state_q == STOP)   && in_window;
  end

  assign edge_cnt   = edge_q;
  assign bit_cnt    = bit_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: per-cycle comparison of all outputs against a model
// that derives every output from the frame-relative cycle index arithmetically.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       sampled_bit = 1'b1;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_check_en, stp_chk_en;
  logic       data_valid, frame_err;

  int checks = 0;
  int failures = 0;
  bit pend_dv = 1'b0;
  bit pend_fe = 1'b0;

  wire [16:0] obs = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                     par_check_en, stp_chk_en, data_valid, frame_err};

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .sampled_bit(sampled_bit), .strt_glitch(strt_glitch), .par_err(par_err),
    .stp_err(stp_err), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
    .par_check_en(par_check_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [16:0] expected);
    checks++;
    assert (obs === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expected);
    end
  endtask

  // Expected outputs at cycle c of a frame (c = 0 is the first START cycle).
  function automatic logic [16:0] model(input int c, input int p, input bit par,
                                        input bit dv, input bit fe);
    int   b, e, f, mid;
    logic deser, strt, parc, stp;
    b     = c / p;
    e     = c % p;
    f     = par ? 11 : 10;
    mid   = p / 2 + 1;
    deser = (b >= 1) && (b <= 8) && (e == p - 1);
    strt  = (b == 0) && (e >= mid);
    parc  = par && (b == 9) && (e >= mid);
    stp   = (b == f - 1) && (e >= mid);
    return {6'(e), 4'(b), 1'b1, deser, strt, parc, stp, dv, fe};
  endfunction

  task automatic run_frame(input logic [5:0] p_drive, input bit par, input logic [7:0] d,
                           input bit perr, input bit serr, input bit glitch,
                           input bit chain_in, input bit chain_out, input int abort_at,
                           input string tag);
    int p, f, len;
    bit parity;
    p      = (p_drive == 6'd16 || p_drive == 6'd32) ? int'(p_drive) : 8;
    f      = par ? 11 : 10;
    len    = glitch ? p : f * p;
    parity = ^d;
    if (!chain_in) begin
      Prescale = p_drive;
      PAR_EN   = par;
      RX_IN    = 1'b0;
      @(negedge CLK);
    end
    for (int c = 0; c < len; c++) begin
      int b, e;
      b = c / p;
      e = c % p;
      check($sformatf("%s_c%0d", tag, c), model(c, p, par, pend_dv, pend_fe));
      pend_dv = 1'b0;
      pend_fe = 1'b0;
      if (c == abort_at) begin
        RST = 1'b0;
        #1;
        check($sformatf("%s_rst_async", tag), 17'd0);
        RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        @(negedge CLK);
        check($sformatf("%s_rst_hold", tag), 17'd0);
        RST = 1'b1;
        @(negedge CLK);
        check($sformatf("%s_rst_idle", tag), 17'd0);
        return;
      end
      if (glitch)               RX_IN = (c < 3) ? 1'b0 : 1'b1;
      else if (b == 0)          RX_IN = 1'b0;
      else if (b <= 8)          RX_IN = d[b-1];
      else if (par && b == 9)   RX_IN = parity;
      else                      RX_IN = 1'b1;
      if (chain_out && c == len - 1) RX_IN = 1'b0;
      sampled_bit = RX_IN;
      strt_glitch = glitch && (b == 0) && (e >= p / 2 + 1);
      par_err     = perr && par && (b == 9) && (e >= p / 2 + 1);
      stp_err     = serr && (b == f - 1) && (e >= p / 2 + 1);
      // Mid-frame configuration noise must be ignored by the latched copies.
      Prescale = (c == len - 1) ? p_drive : 6'($urandom);
      PAR_EN   = (c == len - 1) ? par : 1'($urandom);
      @(negedge CLK);
    end
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    if (!chain_out) RX_IN = 1'b1;
    if (!glitch) begin
      pend_fe = serr || (par && perr);
      pend_dv = !pend_fe;
    end
    if (!chain_out) begin
      check($sformatf("%s_end", tag), {15'd0, pend_dv, pend_fe});
      pend_dv = 1'b0;
      pend_fe = 1'b0;
    end
  endtask

  initial begin
    logic [5:0] psel;
    bit         par_r, chain_r;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset", 17'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_after_reset", 17'd0);

    run_frame(6'd8,  1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "good_par");
    run_frame(6'd16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "good_nopar");
    run_frame(6'd8,  1'b0, 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, "glitch");
    run_frame(6'd8,  1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, "par_err");
    run_frame(6'd8,  1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "after_perr");
    run_frame(6'd8,  1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, "stp_err");
    run_frame(6'd8,  1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, "b2b_1");
    run_frame(6'd8,  1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, "b2b_2");
    run_frame(6'd8,  1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30, "abort");
    run_frame(6'd8,  1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "after_abort");
    run_frame(6'd5,  1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "illegal_presc");
    run_frame(6'd32, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, "p32_b2b_1");
    run_frame(6'd32, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, "p32_b2b_2");

    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       psel = 6'd8;
        1:       psel = 6'd16;
        default: psel = 6'd32;
      endcase
      par_r   = 1'($urandom);
      chain_r = 1'($urandom);
      run_frame(psel, par_r, 8'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), 1'b0, 1'b0, chain_r, -1,
                $sformatf("rand%0d_a", i));
      if (chain_r) begin
        run_frame(psel, par_r, 8'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), 1'b0, 1'b1, 1'b0, -1,
                  $sformatf("rand%0d_b", i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Sequencing controller for the UART receive datapath. It owns the oversampling edge counter and the bit counter.
- It generates the enables for the data sampler, deserializer, start checker, parity checker and stop checker, and decides frame acceptance.
- The parity checker is combinational: it compares `parity_bit` (from the sampler) with the calculated parity only while `par_check_en` is high, and returns `par_err`. This controller uses that result.
- Frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.

Parameters:
- `DATA_WIDTH`, 8, number of data bits per frame.
- `PRESC_WIDTH`, 6, width of the prescale input and the edge counter.

Ports:
- `CLK`  input  1  receive clock (oversampling clock).
- `RST`  input  1  asynchronous reset, active-low.
- `RX_IN`  input  1  serial line; idle high.
- `PAR_EN`  input  1  parity bit present in frame.
- `Prescale`  input  6  oversampling ratio; legal values 8, 16, 32.
- `sampled_bit`  input  1  majority-voted bit from the sampler; valid from `edge_cnt == Prescale/2+1` to the end of the bit.
- `strt_glitch`  input  1  start checker result; meaningful while `strt_chk_en` is high.
- `par_err`  input  1  parity checker result; meaningful while `par_check_en` is high.
- `stp_err`  input  1  stop checker result; meaningful while `stp_chk_en` is high.
- `edge_cnt`  output  6  oversample index within the current bit.
- `bit_cnt`  output  4  bit index within the frame (0 = start).
- `dat_samp_en`  output  1  sampler enable.
- `deser_en`  output  1  deserializer shift strobe.
- `strt_chk_en`  output  1  start check enable.
- `par_check_en`  output  1  parity check enable.
- `stp_chk_en`  output  1  stop check enable.
- `data_valid`  output  1  one-cycle pulse: deserializer byte is good.
- `frame_err`  output  1  one-cycle pulse: frame dropped (parity or stop error).

Behaviour:
- **Reset.** On `RST` low: state IDLE; `edge_cnt`, `bit_cnt`, `data_valid`, `frame_err` and all internal flags go to 0.
  - All enables are combinational decodes of state/count, so they are 0 in IDLE.
  - A reset mid-frame aborts the frame with no `data_valid`.
- **Latching.** `Prescale` and `PAR_EN` are latched on the IDLE->START transition; mid-frame changes are ignored. A latched `Prescale` other than 8/16/32 is treated as 8.
- **Counters.**
  - Both counters hold at 0 in IDLE.
  - Otherwise `edge_cnt` increments every cycle and wraps from P-1 to 0, where P is the latched prescale.
  - `bit_cnt` increments on each wrap.
  - "Bit end" means the cycle with `edge_cnt == P-1`.
- **States:**
  - **IDLE.** If `RX_IN == 0`, go to START; the first START cycle has `edge_cnt = 0`, `bit_cnt = 0`.
  - **START.** `strt_chk_en` is high for `edge_cnt >= P/2+1`. At bit end: if `strt_glitch`, go to IDLE (counters cleared); else go to DATA with `bit_cnt = 1`.
  - **DATA.** `deser_en` pulses at each bit end. At bit end with `bit_cnt == DATA_WIDTH`, go to PARITY if the latched `PAR_EN` is set, else to STOP.
  - **PARITY** (`bit_cnt = 9`). `par_check_en` is high for `edge_cnt >= P/2+1`. At bit end, `par_err` is captured into an internal `err_q`; always go to STOP so framing is kept.
  - **STOP.** `stp_chk_en` is high for `edge_cnt >= P/2+1`. At bit end:
    - if `stp_err | err_q`, pulse `frame_err`; else pulse `data_valid`.
    - clear `err_q`.
    - if `RX_IN == 0` in that cycle, go straight to START with `edge_cnt = 0` (back-to-back frames without a lost cycle); else go to IDLE.
- **Sampler enable.** `dat_samp_en` is high in every state except IDLE.
- **Output timing.** `data_valid` and `frame_err` are registered and high exactly one cycle, the cycle after the STOP bit end. They are never high together.
- **Frame length.** With F = 10 bits (no parity) or 11 bits (parity), a frame takes F*P cycles from the first START cycle. `data_valid` is asserted at cycle F*P.

Test Plan:
- **Good frame, parity.** P=8, `PAR_EN=1`, byte 0xA5, correct parity, good stop -> `deser_en` 8 pulses at cycles 15, 23, …, 71; `par_check_en` high cycles 77-79; `data_valid` high only at cycle 88; `frame_err` stays 0.
- **Good frame, no parity.** P=16, `PAR_EN=0`, byte 0x3C -> PARITY never entered, `par_check_en` never high; `data_valid` pulses at cycle 160.
- **Start glitch.** P=8, `RX_IN` low for 3 cycles then high, `strt_glitch=1` at cycle 7 -> return to IDLE at cycle 8 with counters 0; no `deser_en`, `data_valid` or `frame_err`.
- **Parity error.** P=8, `PAR_EN=1`, `par_err=1` during PARITY -> STOP still entered at cycle 80; `frame_err` pulses at cycle 88; `data_valid` stays 0. A following good frame yields `data_valid` (`err_q` cleared).
- **Stop error, then back-to-back frames.** P=8:
  - stop error: `stp_err=1` -> `frame_err` at cycle 88.
  - back-to-back: two frames, `RX_IN` low in the stop bit-end cycle -> second frame starts at cycle 88 with `edge_cnt=0`; second `data_valid` at cycle 176.
- **Async reset mid-frame.** `RST` low at cycle 30 of a P=8 frame -> all outputs 0 immediately; no `data_valid`; a new frame after release is received correctly.
